// File: rtl/traceback_unit_pkg.sv
// Shared trellis parameters and traceback FSM encoding for the radix-4 Viterbi decoder.
package traceback_unit_pkg;
    localparam int MAX_STATE_NUM = 256;
    localparam int RADIX         = 4;
    localparam int DEF_TB_DEPTH  = 16;
    localparam int ST_W          = $clog2(MAX_STATE_NUM);
    localparam int SYM_W         = $clog2(RADIX);

    typedef logic [1:0] tbu_state_t;
    localparam tbu_state_t ST_FILL  = 2'd0;
    localparam tbu_state_t ST_TRACE = 2'd1;
    localparam tbu_state_t ST_EMIT  = 2'd2;

    // The ACS stage shifts the input pair in LSB-first, so the decoded symbol is bit-reversed.
    function automatic logic [SYM_W-1:0] state_to_sym(input logic [ST_W-1:0] st);
        return {st[0], st[1]};
    endfunction
endpackage

// File: rtl/traceback_unit_survivor_mem.sv
// Survivor register file: one full column written per cycle, one (column, state) entry read combinationally.
module survivor_mem
    import traceback_unit_pkg::*;
#(
    parameter int TB_DEPTH = DEF_TB_DEPTH,
    parameter int COL_W    = $clog2(TB_DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic [ST_W-1:0]  wr_data [MAX_STATE_NUM],
    input  logic [COL_W-1:0] rd_col,
    input  logic [ST_W-1:0]  rd_st,
    output logic [ST_W-1:0]  rd_data
);
    logic [ST_W-1:0] mem [TB_DEPTH][MAX_STATE_NUM];

    // NOTE: storage has no reset; every column is rewritten before the trace reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int s = 0; s < MAX_STATE_NUM; s++) begin
                mem[wr_col][s] <= wr_data[s];
            end
        end
    end

    assign rd_data = mem[rd_col][rd_st];
endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: buffers TB_DEPTH survivor columns, walks them back from the best state, then emits the frame in order.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int TB_DEPTH = DEF_TB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_tbu,
    input  logic [ST_W-1:0]  i_fwd_prv_st [MAX_STATE_NUM],
    input  logic [ST_W-1:0]  i_sel_node,
    output logic             o_ready,
    output logic [SYM_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_last
);
    localparam int               PTR_W    = $clog2(TB_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TB_DEPTH - 1);

    tbu_state_t       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tb_ptr;
    logic [PTR_W-1:0] rd_idx;
    logic [ST_W-1:0]  cur_st;
    logic [ST_W-1:0]  prv_st;
    logic [SYM_W-1:0] sym_buf [TB_DEPTH];
    logic             col_we;

    assign o_ready = (state == ST_FILL);
    assign col_we  = o_ready && en_tbu;

    survivor_mem #(.TB_DEPTH(TB_DEPTH)) u_survivor_mem (
        .clk     (clk),
        .wr_en   (col_we),
        .wr_col  (wr_ptr),
        .wr_data (i_fwd_prv_st),
        .rd_col  (tb_ptr),
        .rd_st   (cur_st),
        .rd_data (prv_st)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_FILL;
            wr_ptr  <= '0;
            tb_ptr  <= '0;
            rd_idx  <= '0;
            cur_st  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (en_tbu) begin
                        if (wr_ptr == PTR_LAST) begin
                            cur_st <= i_sel_node;
                            tb_ptr <= PTR_LAST;
                            wr_ptr <= '0;
                            state  <= ST_TRACE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_TRACE: begin
                    cur_st <= prv_st;
                    if (tb_ptr == '0) begin
                        rd_idx <= '0;
                        state  <= ST_EMIT;
                    end else begin
                        tb_ptr <= tb_ptr - 1'b1;
                    end
                end
                ST_EMIT: begin
                    // The cycle after the last symbol is shown drops the outputs and reopens FILL.
                    if (o_last) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        o_data  <= '0;
                        state   <= ST_FILL;
                    end else begin
                        o_valid <= 1'b1;
                        o_data  <= sym_buf[rd_idx];
                        o_last  <= (rd_idx == PTR_LAST);
                        rd_idx  <= (rd_idx == PTR_LAST) ? '0 : rd_idx + 1'b1;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    o_data  <= '0;
                    state   <= ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == ST_TRACE) begin
            sym_buf[tb_ptr] <= state_to_sym(cur_st);
        end
    end
endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter TB_DEPTH, default 16, traceback/frame length in trellis columns (power of two, >= 2).
REQ-002 SHALL use MAX_STATE_NUM, default 256, trellis state count, and RADIX, default 4, branches per state, from the shared parameter file.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: en_tbu  input  1  column-valid strobe from the ACS stage.
REQ-006 SHALL have port: i_fwd_prv_st  input  [MAX_STATE_NUM] x 8  survivor column (index: state, value: chosen previous state).
REQ-007 SHALL have port: i_sel_node  input  8  minimum-metric state from ACS.
REQ-008 SHALL have port: o_ready  output  1  high when a column can be accepted; the decoder top gates en_acs with it.
REQ-009 SHALL have port: o_data  output  2  decoded radix-4 symbol.
REQ-010 SHALL have port: o_valid  output  1  o_data valid this cycle.
REQ-011 SHALL have port: o_last  output  1  final symbol of a frame, qualified by o_valid.

Function
REQ-012 SHALL implement FSM states FILL, TRACE and EMIT; o_ready SHALL be 1 exactly when the state is FILL, decoded from the state register.
REQ-013 In FILL, each cycle with en_tbu=1 SHALL write i_fwd_prv_st into column wr_ptr and increment wr_ptr; en_tbu=0 SHALL hold all state.
REQ-014 On the write with wr_ptr=TB_DEPTH-1, SHALL latch i_sel_node as cur_st, set tb_ptr=TB_DEPTH-1, clear wr_ptr and go to TRACE.
REQ-015 In TRACE, each cycle SHALL store sym_buf[tb_ptr] <= {cur_st[0],cur_st[1]} (bit-reversed input pair), set cur_st <= mem[tb_ptr][cur_st], and decrement tb_ptr.
REQ-016 After the tb_ptr=0 step, i.e. exactly TB_DEPTH TRACE cycles, SHALL go to EMIT with rd_idx=0.
REQ-017 In EMIT, SHALL drive registered o_valid=1 and o_data=sym_buf[rd_idx], incrementing rd_idx each cycle, for TB_DEPTH consecutive cycles.
REQ-018 o_last SHALL be 1 with the symbol at rd_idx=TB_DEPTH-1; the next cycle SHALL be FILL with o_ready=1 and o_valid=0.
REQ-019 Latency: if the last column is written at edge N, o_valid SHALL be high for edges N+TB_DEPTH+1 through N+2*TB_DEPTH, with no gaps and no downstream backpressure.
REQ-020 en_tbu in TRACE or EMIT SHALL be ignored: no write, no pointer change.
REQ-021 Outside EMIT, o_data SHALL be 0 and o_valid and o_last SHALL be 0.
REQ-022 All pointers SHALL be log2(TB_DEPTH) bits wide and SHALL never wrap silently; transitions occur only at the terminal counts above.

Reset
REQ-023 When rst=0 at a clock edge, the block SHALL enter FILL with wr_ptr=0, tb_ptr=0, rd_idx=0, cur_st=0, o_valid=0, o_last=0 and o_data=0; o_ready SHALL be 1 from that edge.
REQ-024 A reset in any state, including mid-TRACE or mid-EMIT, SHALL discard the partial frame; survivor memory and sym_buf contents need not be cleared.

Structure
REQ-025 TB_DEPTH SHALL be added as a define in param_def.sv alongside MAX_STATE_NUM and RADIX; the FSM state enum SHALL be a typedef there.
REQ-026 Survivor storage SHALL be a sub-module survivor_mem: TB_DEPTH x MAX_STATE_NUM x 8 register file, one synchronous write port and one combinational read port (column, state).

Verification
REQ-027 Reset: hold rst=0 for 3 cycles -> o_ready=1, o_valid=0, o_last=0, o_data=2'b00.
REQ-028 All survivor entries 8'h00, i_sel_node=8'h00, 16 columns -> 16 symbols 2'b00, o_last on the 16th, first o_valid 17 cycles after the last write.
REQ-029 All survivor entries 8'h02, i_sel_node=8'h01 -> emitted 2'b01 fifteen times, then 2'b10 with o_last=1.
REQ-030 en_tbu toggled 1,0,1,0 during FILL, and held high through TRACE/EMIT -> exactly 16 accepted writes per frame, o_ready=0 throughout TRACE/EMIT, output unchanged from REQ-029.
REQ-031 rst=0 for one cycle at the 5th EMIT symbol -> next cycle o_valid=0 and o_ready=1; a following REQ-029 frame decodes correctly.
REQ-032 Two back-to-back frames with en_tbu held high -> second frame's first write occurs the cycle after o_last, and both outputs are correct.
